// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - RV32I 5-stage pipeline control: decode, forwarding, load-use stall, branch flush
// Optional PIPE_CTRL_PERF_EN adds stall_cnt/flush_cnt event counters.
module pipe_ctrl #(
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_d,
    input  logic        BrEq,
    input  logic        BrLt,
    output logic [3:0]  ALUSel,
    output logic        ASel,
    output logic        BSel,
    output logic        BrUn,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        stall,
    output logic        flush,
    output logic        PCSel,
    output logic        MemRW,
    output logic        RegWEn,
    output logic [1:0]  WBSel,
`ifdef PIPE_CTRL_PERF_EN
    output logic [4:0]  rd_w,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`else
    output logic [4:0]  rd_w
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] WB_MEM = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_M  = 2'd1;
    localparam logic [1:0] FWD_W  = 2'd2;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_IALU, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
            default:                                                    writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: reads_rs1 = 1'b1;
            default:                                              reads_rs1 = 1'b0;
        endcase
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
            default:                   reads_rs2 = 1'b0;
        endcase
    endfunction

    // alt is instr[30]: selects SUB (R-type only) and SRA (R and I shifts)
    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'b000:  alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic used,
                                           input logic wr_m, input logic [4:0] rd_m,
                                           input logic wr_w, input logic [4:0] rd_wb);
        if (used && wr_m && rd_m != 5'd0 && rd_m == src)
            fwd_sel = FWD_M;
        else if (used && wr_w && rd_wb != 5'd0 && rd_wb == src)
            fwd_sel = FWD_W;
        else
            fwd_sel = FWD_RF;
    endfunction

    logic [31:0] inst_x, inst_m, inst_w;

    logic [6:0] op_d, op_x, op_m, op_w;
    logic [4:0] rs1_d, rs2_d, rs1_x, rs2_x, rd_x, rd_m;
    logic [2:0] f3_x;
    logic       taken, load_use;

    assign op_d  = inst_d[6:0];
    assign rs1_d = inst_d[19:15];
    assign rs2_d = inst_d[24:20];
    assign op_x  = inst_x[6:0];
    assign rd_x  = inst_x[11:7];
    assign f3_x  = inst_x[14:12];
    assign rs1_x = inst_x[19:15];
    assign rs2_x = inst_x[24:20];
    assign op_m  = inst_m[6:0];
    assign rd_m  = inst_m[11:7];
    assign op_w  = inst_w[6:0];

    logic unused_bits;
    assign unused_bits = ^{inst_d[31:25], inst_d[14:7], inst_x[31], inst_x[29:25],
                           inst_m[31:12], inst_w[31:12]};

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_x <= NOP_INST;
            inst_m <= NOP_INST;
            inst_w <= NOP_INST;
        end else begin
            inst_x <= (taken || stall) ? NOP_INST : inst_d;
            inst_m <= inst_x;
            inst_w <= inst_m;
        end
    end

    always_comb begin
        ALUSel = ALU_ADD;
        ASel   = 1'b1;
        BSel   = 1'b0;
        BrUn   = 1'b0;
        case (op_x)
            OP_R: begin
                BSel   = 1'b1;
                ALUSel = alu_op(f3_x, inst_x[30], 1'b1);
            end
            OP_IALU:       ALUSel = alu_op(f3_x, inst_x[30], 1'b0);
            OP_LUI:        ALUSel = ALU_PASSB;
            OP_AUIPC,
            OP_JAL:        ASel = 1'b0;
            OP_BRANCH: begin
                ASel = 1'b0;
                BrUn = (f3_x[2:1] == 2'b11);
            end
            default: ;
        endcase
    end

    always_comb begin
        fwd_a = fwd_sel(rs1_x, reads_rs1(op_x), writes_rd(op_m), rd_m, writes_rd(op_w), rd_w);
        fwd_b = fwd_sel(rs2_x, reads_rs2(op_x), writes_rd(op_m), rd_m, writes_rd(op_w), rd_w);
    end

    always_comb begin
        taken = 1'b0;
        case (op_x)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BRANCH: begin
                case (f3_x)
                    3'b000:         taken = BrEq;
                    3'b001:         taken = !BrEq;
                    3'b100, 3'b110: taken = BrLt;
                    3'b101, 3'b111: taken = !BrLt;
                    default:        taken = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    // A taken branch discards the D instruction, so it overrides the load-use stall
    assign load_use = (op_x == OP_LOAD) && (rd_x != 5'd0) &&
                      ((reads_rs1(op_d) && rs1_d == rd_x) || (reads_rs2(op_d) && rs2_d == rd_x));
    assign stall  = load_use && !taken;
    assign flush  = taken;
    assign PCSel  = taken;

    assign MemRW  = (op_m == OP_STORE);
    assign RegWEn = writes_rd(op_w);
    assign rd_w   = inst_w[11:7];

    always_comb begin
        case (op_w)
            OP_LOAD:         WBSel = WB_MEM;
            OP_JAL, OP_JALR: WBSel = WB_PC4;
            default:         WBSel = WB_ALU;
        endcase
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall) stall_cnt <= stall_cnt + 32'd1;
            if (flush) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl against an instruction-level pipeline model
module tb_pipe_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;

    localparam int K_NONE = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                   K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_d;
    logic        BrEq, BrLt;
    logic [3:0]  ALUSel;
    logic        ASel, BSel, BrUn;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, flush, PCSel, MemRW, RegWEn;
    logic [1:0]  WBSel;
    logic [4:0]  rd_w;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl dut (
        .clk(clk), .reset(reset), .inst_d(inst_d), .BrEq(BrEq), .BrLt(BrLt),
        .ALUSel(ALUSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .flush(flush), .PCSel(PCSel),
        .MemRW(MemRW), .RegWEn(RegWEn), .WBSel(WBSel),
`ifdef PIPE_CTRL_PERF_EN
        .rd_w(rd_w), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
        .rd_w(rd_w)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int rd, rs1, rs2, f3;
        bit alt, wr, r1, r2;
    } info_t;

    typedef logic [22:0] obs_t;

    obs_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] st_x = NOP, st_m = NOP, st_w = NOP;
    int          exp_scnt = 0, exp_fcnt = 0;
    bit          last_stall = 1'b0;

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic info_t info(input logic [31:0] w);
        info_t n;
        n.rd = int'(w[11:7]); n.rs1 = int'(w[19:15]); n.rs2 = int'(w[24:20]);
        n.f3 = int'(w[14:12]); n.alt = w[30];
        case (w[6:0])
            7'h33:   n.kind = K_R;
            7'h13:   n.kind = K_I;
            7'h03:   n.kind = K_LD;
            7'h23:   n.kind = K_ST;
            7'h63:   n.kind = K_BR;
            7'h6f:   n.kind = K_JAL;
            7'h67:   n.kind = K_JALR;
            7'h37:   n.kind = K_LUI;
            7'h17:   n.kind = K_AUIPC;
            default: n.kind = K_NONE;
        endcase
        n.wr = n.kind inside {K_R, K_I, K_LD, K_LUI, K_AUIPC, K_JAL, K_JALR};
        n.r1 = n.kind inside {K_R, K_I, K_LD, K_ST, K_BR, K_JALR};
        n.r2 = n.kind inside {K_R, K_ST, K_BR};
        return n;
    endfunction

    function automatic int alu_of(input info_t x);
        if (x.kind == K_LUI) return 10;
        if (x.kind != K_R && x.kind != K_I) return 0;
        case (x.f3)
            0:       return (x.kind == K_R && x.alt) ? 1 : 0;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 5;
            5:       return x.alt ? 7 : 6;
            6:       return 8;
            default: return 9;
        endcase
    endfunction

    function automatic int fwd_of(input int r, input bit used, input info_t m, input info_t w);
        if (!used || r == 0) return 0;
        if (m.wr && m.rd == r) return 1;
        if (w.wr && w.rd == r) return 2;
        return 0;
    endfunction

    function automatic bit taken_of(input info_t x, input bit eq, input bit lt);
        if (x.kind == K_JAL || x.kind == K_JALR) return 1'b1;
        if (x.kind != K_BR) return 1'b0;
        case (x.f3)
            0:       return eq;
            1:       return !eq;
            4, 6:    return lt;
            5, 7:    return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_perf();
`ifdef PIPE_CTRL_PERF_EN
        n_tests++;
        if (stall_cnt !== 32'(exp_scnt) || flush_cnt !== 32'(exp_fcnt)) begin
            n_fail++;
            $display("FAIL perf_counters cycle %0d: got stall_cnt=%0d flush_cnt=%0d, expected %0d %0d",
                     cyc, stall_cnt, flush_cnt, exp_scnt, exp_fcnt);
        end
`endif
    endtask

    task automatic step(input logic [31:0] d, input bit eq, input bit lt, input bit rst);
        info_t x, m, w, dd;
        obs_t  e;
        bit    tk, stl;
        int    wb;
        @(posedge clk);
        #1;
        cyc++;
        check_perf();
        inst_d = d; BrEq = eq; BrLt = lt; reset = rst;
        x = info(st_x); m = info(st_m); w = info(st_w); dd = info(d);
        tk  = taken_of(x, eq, lt);
        stl = !tk && x.kind == K_LD && x.rd != 0 &&
              ((dd.r1 && dd.rs1 == x.rd) || (dd.r2 && dd.rs2 == x.rd));
        wb  = (w.kind == K_LD) ? 0 : (w.kind == K_JAL || w.kind == K_JALR) ? 2 : 1;
        e = {4'(alu_of(x)),
             !(x.kind == K_AUIPC || x.kind == K_JAL || x.kind == K_BR),
             x.kind == K_R,
             x.kind == K_BR && x.f3 >= 6,
             2'(fwd_of(x.rs1, x.r1, m, w)),
             2'(fwd_of(x.rs2, x.r2, m, w)),
             stl, tk, tk,
             m.kind == K_ST,
             w.wr,
             2'(wb),
             5'(w.rd)};
        sb.push_back(e);
        last_stall = stl;
        if (rst) begin
            st_x = NOP; st_m = NOP; st_w = NOP;
            exp_scnt = 0; exp_fcnt = 0;
        end else begin
            st_w = st_m;
            st_m = st_x;
            st_x = (tk || stl) ? NOP : d;
            exp_scnt += int'(stl);
            exp_fcnt += int'(tk);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            a = {ALUSel, ASel, BSel, BrUn, fwd_a, fwd_b, stall, flush, PCSel, MemRW, RegWEn, WBSel, rd_w};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cycle %0d inst_d=%h: got %h expected %h", cyc, inst_d, a, e);
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        int         k   = $urandom_range(0, 10);
        int         t   = $urandom_range(0, 5);
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [2:0] f3  = 3'($urandom_range(0, 7));
        logic [6:0] f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        case (k)
            0:       return enc(7'h33, rd, f3, rs1, rs2, (f3 == 0 || f3 == 5) ? f7 : 7'h00);
            1:       return enc(7'h13, rd, f3, rs1, rs2, (f3 == 5) ? f7 : (f3 == 1) ? 7'h00 : 7'($urandom));
            2:       return enc(7'h03, rd, 3'd2, rs1, rs2, 7'h00);
            3:       return enc(7'h23, rd, 3'd2, rs1, rs2, 7'h00);
            4:       return enc(7'h63, rd, (t < 2) ? 3'(t) : 3'(t + 2), rs1, rs2, 7'h00);
            5:       return enc(7'h6f, rd, f3, rs1, rs2, 7'($urandom));
            6:       return enc(7'h67, rd, 3'd0, rs1, rs2, 7'h00);
            7:       return enc(7'h37, rd, f3, rs1, rs2, 7'($urandom));
            8:       return enc(7'h17, rd, f3, rs1, rs2, 7'($urandom));
            9:       return NOP;
            default: return enc(7'h7f, rd, f3, rs1, rs2, f7);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] add5, sub6, lw7, add8, addi8, beq, bltu, lw9, beq9, jal1, d;
        add5  = enc(7'h33, 5'd5, 3'd0, 5'd1, 5'd2, 7'h00);
        sub6  = enc(7'h33, 5'd6, 3'd0, 5'd5, 5'd5, 7'h20);
        lw7   = enc(7'h03, 5'd7, 3'd2, 5'd1, 5'd0, 7'h00);
        add8  = enc(7'h33, 5'd8, 3'd0, 5'd7, 5'd3, 7'h00);
        addi8 = enc(7'h13, 5'd8, 3'd0, 5'd3, 5'd7, 7'h00);
        beq   = enc(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00);
        bltu  = enc(7'h63, 5'd0, 3'd6, 5'd1, 5'd2, 7'h00);
        lw9   = enc(7'h03, 5'd9, 3'd2, 5'd1, 5'd0, 7'h00);
        beq9  = enc(7'h63, 5'd4, 3'd0, 5'd9, 5'd0, 7'h00);
        jal1  = enc(7'h6f, 5'd1, 3'd0, 5'd0, 5'd0, 7'h00);

        reset = 1'b1; inst_d = 32'hdeadbeef; BrEq = 1'b0; BrLt = 1'b0;
        repeat (2) @(posedge clk);

        step(32'h12345678, 1, 1, 1);
        step(rand_inst(), 1, 0, 1);
        repeat (3) step(NOP, 0, 0, 0);

        step(add5, 0, 0, 0); step(sub6, 0, 0, 0); repeat (3) step(NOP, 0, 0, 0);
        step(add5, 0, 0, 0); step(NOP, 0, 0, 0); step(sub6, 0, 0, 0); repeat (3) step(NOP, 0, 0, 0);
        step(enc(7'h33, 5'd0, 3'd0, 5'd1, 5'd2, 7'h00), 0, 0, 0);
        step(enc(7'h33, 5'd6, 3'd0, 5'd0, 5'd0, 7'h20), 0, 0, 0);
        repeat (3) step(NOP, 0, 0, 0);

        step(lw7, 0, 0, 0); step(add8, 0, 0, 0); step(add8, 0, 0, 0); repeat (3) step(NOP, 0, 0, 0);
        step(lw7, 0, 0, 0); step(addi8, 0, 0, 0); repeat (3) step(NOP, 0, 0, 0);

        step(beq, 0, 0, 0); step(add5, 1, 0, 0); repeat (2) step(NOP, 0, 0, 0);
        step(beq, 0, 0, 0); step(add5, 0, 1, 0); repeat (2) step(NOP, 0, 0, 0);
        step(bltu, 0, 0, 0); step(add5, 0, 1, 0); repeat (2) step(NOP, 0, 0, 0);

        repeat (2) begin
            step(lw9, 0, 0, 0); step(beq9, 0, 0, 0); step(beq9, 1, 0, 0);
            step(jal1, 1, 0, 0); step(beq9, 0, 0, 0); step(lw9, 0, 0, 0);
        end
        repeat (3) step(NOP, 0, 0, 0);

        d = NOP;
        for (int i = 0; i < 1500; i++) begin
            if (!last_stall) d = rand_inst();
            step(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
        end

        step(lw7, 0, 0, 1);
        step(lw7, 0, 0, 0); step(add8, 0, 0, 0); step(add8, 0, 0, 0);
        step(beq, 0, 0, 0); step(NOP, 1, 0, 0); repeat (3) step(NOP, 0, 0, 0);

        @(posedge clk);
        #1;
        check_perf();
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
